// File: rtl/fetch_seq.sv
// Instruction fetch sequencer: walks one 16-bit instruction as four nibble reads (MSB first),
// drives the one-hot instruction-register nibble enable and owns the program counter.
module fetch_seq #(
   parameter int              PC_W     = 12,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              fetch_start,
   input  logic              pc_load,
   input  logic [PC_W-1:0]   pc_load_val,
   output logic [PC_W+1:0]   mem_addr,
   output logic              mem_rd,
   output logic [3:0]        ir_en,
   output logic [PC_W-1:0]   pc,
   output logic              busy,
   output logic              instr_valid
);

   // state | meaning
   // IDLE  | waiting for fetch_start; pc_load accepted here only
   // N0    | read nibble 0, nothing to load yet
   // N1    | read nibble 1, load IR[15:12]
   // N2    | read nibble 2, load IR[11:8]
   // N3    | read nibble 3, load IR[7:4]
   // LAST  | load IR[3:0], advance pc on exit
   // DONE  | IR complete, instr_valid pulse
   typedef enum logic [2:0] {IDLE, N0, N1, N2, N3, LAST, DONE} state_t;

   state_t     state, state_nxt;
   logic [1:0] nib;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset)                      pc <= RESET_PC;
      else if (state == IDLE && pc_load) pc <= pc_load_val;
      else if (state == LAST)         pc <= pc + PC_W'(1);
   end

   always_comb begin
      state_nxt   = state;
      nib         = 2'd0;
      mem_rd      = 1'b0;
      ir_en       = 4'b0000;
      busy        = 1'b1;
      instr_valid = 1'b0;
      case (state)
         IDLE: begin
            busy = 1'b0;
            if (fetch_start) state_nxt = N0;
         end
         N0: begin
            nib       = 2'd0;
            mem_rd    = 1'b1;
            state_nxt = N1;
         end
         N1: begin
            nib       = 2'd1;
            mem_rd    = 1'b1;
            ir_en     = 4'b1000;
            state_nxt = N2;
         end
         N2: begin
            nib       = 2'd2;
            mem_rd    = 1'b1;
            ir_en     = 4'b0100;
            state_nxt = N3;
         end
         N3: begin
            nib       = 2'd3;
            mem_rd    = 1'b1;
            ir_en     = 4'b0010;
            state_nxt = LAST;
         end
         LAST: begin
            ir_en     = 4'b0001;
            state_nxt = DONE;
         end
         DONE: begin
            instr_valid = 1'b1;
            state_nxt   = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Outside N0..N3 the nibble index is 0, so the address stays defined while mem_rd is low.
   assign mem_addr = {pc, nib};

endmodule

// File: tb/tb_fetch_seq.sv
// Directed bench for fetch_seq: nibble memory and instruction register modelled here,
// expected instructions queued at fetch start and compared when instr_valid pulses.
module tb_fetch_seq;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        fetch_start = 1'b0;
   logic        pc_load = 1'b0;
   logic [11:0] pc_load_val = '0;
   logic [13:0] mem_addr;
   logic        mem_rd;
   logic [3:0]  ir_en;
   logic [11:0] pc;
   logic        busy;
   logic        instr_valid;

   logic [3:0]  mem_data = '0;
   logic [15:0] ir = '0;
   int          total = 0;
   int          passed = 0;
   int          valid_cnt = 0;

   typedef struct {
      logic [15:0] instr;
      logic [11:0] pc_after;
   } exp_t;
   exp_t exp_q[$];

   fetch_seq #(.PC_W(12), .RESET_PC(12'h000)) dut (
      .clk(clk), .reset(reset), .fetch_start(fetch_start), .pc_load(pc_load),
      .pc_load_val(pc_load_val), .mem_addr(mem_addr), .mem_rd(mem_rd), .ir_en(ir_en),
      .pc(pc), .busy(busy), .instr_valid(instr_valid)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] word_at(input logic [11:0] a);
      if (a == 12'h000) return 16'hA5C3;
      return ({4'h0, a} * 16'h9E37) ^ 16'h1357;
   endfunction

   // One-cycle-latency nibble memory; nibble 0 is bits 15:12 of the word.
   always @(posedge clk) begin
      if (mem_rd) begin
         logic [15:0] w;
         w = word_at(mem_addr[13:2]);
         case (mem_addr[1:0])
            2'd0: mem_data <= w[15:12];
            2'd1: mem_data <= w[11:8];
            2'd2: mem_data <= w[7:4];
            default: mem_data <= w[3:0];
         endcase
      end
   end

   always @(posedge clk) begin
      if (ir_en[3]) ir[15:12] <= mem_data;
      if (ir_en[2]) ir[11:8]  <= mem_data;
      if (ir_en[1]) ir[7:4]   <= mem_data;
      if (ir_en[0]) ir[3:0]   <= mem_data;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
   endtask

   // Scoreboard: every instr_valid pulse must match the oldest queued fetch.
   always @(negedge clk) begin
      if (instr_valid === 1'b1) begin
         exp_t e;
         valid_cnt++;
         if (exp_q.size() == 0) begin
            chk("unexpected_instr_valid", 32'd1, 32'd0);
         end else begin
            e = exp_q.pop_front();
            chk("ir_word", {16'h0, ir}, {16'h0, e.instr});
            chk("pc_in_done", {20'h0, pc}, {20'h0, e.pc_after});
         end
      end
   end

   // mode 0: plain fetch, 1: inject fetch_start/pc_load during N2, 2: reset during N3
   task automatic fetch(input logic ld, input logic [11:0] lval, input logic [11:0] spc,
                        input int mode);
      logic [11:0] p;
      logic [3:0]  ir_exp;
      exp_t        e;
      p = ld ? lval : spc;
      fetch_start = 1'b1;
      pc_load     = ld;
      pc_load_val = lval;
      if (mode != 2) begin
         e.instr    = word_at(p);
         e.pc_after = p + 12'd1;
         exp_q.push_back(e);
      end
      @(negedge clk);
      fetch_start = 1'b0;
      pc_load     = 1'b0;
      for (int cyc = 1; cyc <= 5; cyc++) begin
         case (cyc)
            2: ir_exp = 4'b1000;
            3: ir_exp = 4'b0100;
            4: ir_exp = 4'b0010;
            5: ir_exp = 4'b0001;
            default: ir_exp = 4'b0000;
         endcase
         chk($sformatf("busy_c%0d", cyc), {31'h0, busy}, 32'd1);
         chk($sformatf("ir_en_c%0d", cyc), {28'h0, ir_en}, {28'h0, ir_exp});
         chk($sformatf("pc_c%0d", cyc), {20'h0, pc}, {20'h0, p});
         chk($sformatf("mem_rd_c%0d", cyc), {31'h0, mem_rd}, {31'h0, cyc <= 4});
         if (cyc <= 4)
            chk($sformatf("mem_addr_c%0d", cyc), {18'h0, mem_addr},
                {18'h0, p, 2'(cyc - 1)});
         if (mode == 1 && cyc == 3) begin
            fetch_start = 1'b1;
            pc_load     = 1'b1;
            pc_load_val = 12'h050;
         end
         if (mode == 1 && cyc == 4) begin
            fetch_start = 1'b0;
            pc_load     = 1'b0;
         end
         if (mode == 2 && cyc == 4) begin
            #2 reset = 1'b1;
            #1;
            chk("rst_ir_en", {28'h0, ir_en}, 32'd0);
            chk("rst_mem_rd", {31'h0, mem_rd}, 32'd0);
            chk("rst_busy", {31'h0, busy}, 32'd0);
            chk("rst_valid", {31'h0, instr_valid}, 32'd0);
            chk("rst_pc", {20'h0, pc}, 32'h000);
            chk("rst_mem_addr", {18'h0, mem_addr}, 32'h0000);
            @(negedge clk);
            reset = 1'b0;
            return;
         end
         @(negedge clk);
      end
      chk("done_valid", {31'h0, instr_valid}, 32'd1);
      chk("done_ir_en", {28'h0, ir_en}, 32'd0);
      chk("done_mem_rd", {31'h0, mem_rd}, 32'd0);
      chk("done_busy", {31'h0, busy}, 32'd1);
      @(negedge clk);
      chk("idle_busy", {31'h0, busy}, 32'd0);
      chk("idle_valid", {31'h0, instr_valid}, 32'd0);
   endtask

   initial begin
      #2 reset = 1'b1;
      #1;
      chk("init_ir_en", {28'h0, ir_en}, 32'd0);
      chk("init_mem_rd", {31'h0, mem_rd}, 32'd0);
      chk("init_busy", {31'h0, busy}, 32'd0);
      chk("init_valid", {31'h0, instr_valid}, 32'd0);
      chk("init_pc", {20'h0, pc}, 32'h000);
      chk("init_mem_addr", {18'h0, mem_addr}, 32'h0000);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;

      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         chk("idle_hold_busy", {31'h0, busy}, 32'd0);
         chk("idle_hold_ir_en", {28'h0, ir_en}, 32'd0);
      end

      fetch(1'b0, 12'h000, 12'h000, 0);          // single fetch of 0xA5C3
      chk("pc_after_single", {20'h0, pc}, 32'h001);

      fetch(1'b1, 12'h123, 12'h000, 0);          // jump + fetch same cycle
      chk("pc_after_jump", {20'h0, pc}, 32'h124);

      pc_load = 1'b1;
      pc_load_val = 12'hFFF;
      @(negedge clk);
      pc_load = 1'b0;
      chk("pc_loaded_fff", {20'h0, pc}, 32'hFFF);
      chk("load_only_busy", {31'h0, busy}, 32'd0);
      fetch(1'b0, 12'h000, 12'hFFF, 0);          // wrap-around
      chk("pc_after_wrap", {20'h0, pc}, 32'h000);

      fetch(1'b0, 12'h000, 12'h000, 1);          // ignored requests in N2
      chk("pc_after_ignored", {20'h0, pc}, 32'h001);
      for (int i = 0; i < 8; i++) @(negedge clk);
      chk("no_extra_fetch_busy", {31'h0, busy}, 32'd0);
      chk("no_extra_fetch_pc", {20'h0, pc}, 32'h001);

      fetch(1'b0, 12'h000, 12'h001, 2);          // reset during N3
      for (int i = 0; i < 8; i++) @(negedge clk);
      chk("after_abort_busy", {31'h0, busy}, 32'd0);
      chk("after_abort_pc", {20'h0, pc}, 32'h000);

      fetch(1'b0, 12'h000, 12'h000, 0);          // restart from nibble 0
      chk("pc_after_restart", {20'h0, pc}, 32'h001);

      chk("valid_pulse_count", valid_cnt, 32'd5);
      chk("scoreboard_empty", exp_q.size(), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/fetch_seq.md
# fetch_seq

Instruction fetch sequencer sitting directly upstream of the instruction register. It walks the 4-bit-wide instruction memory one nibble at a time, presents nibble addresses, and drives the one-hot 4-bit nibble-enable that loads each nibble (MSB first) into the 16-bit instruction register. It owns the program counter, advances it after every completed fetch, and accepts jump/branch targets between fetches.

## Interface
- `PC_W`, default 12: program-counter width, in 16-bit instruction words; matches the 12-bit jump address field.
- `RESET_PC`, default 0: PC value after reset.
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `fetch_start`  in  1  request one instruction fetch; sampled only in IDLE.
- `pc_load`  in  1  load `pc_load_val` into PC; sampled only in IDLE.
- `pc_load_val`  in  PC_W  new PC (jump/branch target).
- `mem_addr`  out  PC_W+2  nibble address = {pc, nibble index}.
- `mem_rd`  out  1  read strobe; memory returns data on its 4-bit bus the following cycle.
- `ir_en`  out  4  one-hot nibble enable to the instruction register: 1000 = bits 15:12, 0100 = 11:8, 0010 = 7:4, 0001 = 3:0; 0000 = hold.
- `pc`  out  PC_W  current PC.
- `busy`  out  1  high in every state except IDLE.
- `instr_valid`  out  1  one-cycle pulse: instruction register holds the complete new instruction.

## Operation
- States: IDLE, N0, N1, N2, N3, LAST, DONE. State held in a register; outputs decoded from state.
- IDLE: `mem_rd`=0, `ir_en`=0000, `busy`=0. If `fetch_start`, go to N0.
- N0: `mem_addr`={pc,2'd0}, `mem_rd`=1, `ir_en`=0000. Go to N1.
- N1: `mem_addr`={pc,2'd1}, `mem_rd`=1, `ir_en`=1000. Go to N2.
- N2: `mem_addr`={pc,2'd2}, `mem_rd`=1, `ir_en`=0100. Go to N3.
- N3: `mem_addr`={pc,2'd3}, `mem_rd`=1, `ir_en`=0010. Go to LAST.
- LAST: `mem_rd`=0, `ir_en`=0001. PC <= pc+1 at exit edge. Go to DONE.
- DONE: `instr_valid`=1, `ir_en`=0000, `mem_rd`=0. Go to IDLE.
- `mem_addr` outside N0–N3 = {pc,2'd0}; it is don't-care while `mem_rd`=0, but must be stable, with no X.
- Exactly one `ir_en` bit high in N1..LAST; never more than one bit in any cycle.
- PC arithmetic: modulo 2^PC_W; 0xFFF+1 wraps to 0x000 (PC_W=12).
- `pc_load` in IDLE: PC <= `pc_load_val` at that edge. If `fetch_start` is asserted in the same cycle, the fetch proceeds, and N0 addresses the newly loaded PC.
- `fetch_start` and `pc_load` outside IDLE are ignored, not queued. This includes DONE; a back-to-back fetch requires `fetch_start` in the IDLE cycle following DONE.
- Reset, asynchronous and at any state including mid-fetch: state=IDLE, pc=RESET_PC, `ir_en`=0000, `mem_rd`=0, `busy`=0, `instr_valid`=0, `mem_addr`={RESET_PC,2'd0}. A partially loaded instruction is abandoned, with no PC increment and no `instr_valid`.

## Timing
- Edge E0: `fetch_start` sampled in IDLE.
- The cycles after E0 are N0, N1, N2, N3, LAST, DONE.
- `instr_valid` is high in the 6th cycle after E0.
- Minimum start-to-start spacing is 7 cycles.
- Memory read latency is 1 cycle: the nibble addressed in cycle k is on the bus in cycle k+1, when the matching `ir_en` bit is high.
- `pc` changes at the LAST→DONE edge; during DONE, `pc` already shows the next instruction's address.
- `busy` rises in the cycle after E0 and falls when IDLE is re-entered after DONE.

## Test plan
- Reset then idle: assert `reset` asynchronously mid-cycle → all outputs take the reset values listed above immediately. Release reset, hold `fetch_start`=0 for 10 cycles → `busy`=0, `ir_en`=0000 throughout.
- Single fetch: memory word 0 = 0xA5C3, one-cycle `fetch_start` → `mem_addr` sequence 0,1,2,3 in N0..N3; `ir_en` sequence 1000,0100,0010,0001; instruction register = 0xA5C3 when `instr_valid` pulses in cycle 6; `pc`=1.
- Jump plus fetch in the same cycle: `pc_load`=1, `pc_load_val`=0x123, `fetch_start`=1 in IDLE → N0 `mem_addr`=0x48C; after DONE, `pc`=0x124.
- Wrap-around: load 0xFFF, then fetch → addresses 0x3FFC..0x3FFF; `pc`=0x000 afterwards.
- Ignored requests: pulse `fetch_start` and `pc_load` (value 0x050) during N2 → no extra fetch, `pc` unchanged by the load, single `instr_valid` pulse.
- Reset mid-fetch: assert `reset` in N3 → immediate IDLE, `ir_en`=0000, `pc`=RESET_PC, no `instr_valid` pulse. The next fetch restarts at nibble 0.
